fa_17bit: RTL and testbench

Parameterised binary adder. Default width is 17 bits. It produces `{cout, S} = A + B + cin` combinationally, with zero-cycle latency. A registered copy of the result, including a signed-overflow flag, is captured on the clock for pipelined consumers. It is the arithmetic leaf used wherever a wide add-with-carry is needed.

---
 rtl/fa_17bit.sv | 130 +++++++++++++
 tb/tb_fa_17bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fa_17bit.sv
// Parameterised add-with-carry: combinational {cout, S} = A + B + cin plus a registered copy with signed overflow.
// Build option FA_17BIT_CLA_EN selects 4-bit carry-lookahead groups instead of a plain ripple chain.

`ifndef FA_17BIT_CLA_EN
module fa_17bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule
`endif

module fa_17bit #(
    parameter int unsigned width = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             cin,
    input  logic             en,
    output logic [width-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic [width-1:0] S_q,
    output logic             cout_q,
    output logic             ovf_q
);

    localparam int unsigned msb = width - 1;

`ifdef FA_17BIT_CLA_EN
    localparam int unsigned num_grp = (width + 3) / 4;

    // Each group takes its carry-in from the previous group's block-local carry-out.
    for (genvar gi = 0; gi < num_grp; gi++) begin : g_grp
        localparam int unsigned lo = 4 * gi;
        localparam int unsigned gw = ((width - lo) >= 4) ? 4 : (width - lo);

        logic          ci;
        logic          co;
        logic [gw-1:0] g;
        logic [gw-1:0] p;
        logic [gw-1:0] c;
        logic          grp_g;
        logic          grp_p;
        logic          term;
        logic          pp;

        if (gi == 0) begin : g_first
            assign ci = cin;
        end else begin : g_chain
            assign ci = g_grp[gi-1].co;
        end

        assign g = A[lo +: gw] & B[lo +: gw];
        assign p = A[lo +: gw] ^ B[lo +: gw];

        // Carry k is the lookahead sum of products g[j] & p[j+1..k-1], plus the all-propagate term with ci.
        always_comb begin
            c    = '0;
            term = 1'b0;
            pp   = 1'b1;
            for (int unsigned k = 0; k < gw; k++) begin
                term = 1'b0;
                pp   = 1'b1;
                for (int unsigned jj = 0; jj < k; jj++) begin
                    term = term | (pp & g[k-1-jj]);
                    pp   = pp & p[k-1-jj];
                end
                c[k] = term | (pp & ci);
            end
        end

        always_comb begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int unsigned j = 0; j < gw; j++) begin
                grp_g = g[j] | (p[j] & grp_g);
                grp_p = grp_p & p[j];
            end
        end

        assign co          = grp_g | (grp_p & ci);
        assign S[lo +: gw] = p ^ c;
    end

    assign cout = g_grp[num_grp-1].co;
`else
    for (genvar i = 0; i < width; i++) begin : g_bit
        logic ci;
        logic co;

        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_chain
            assign ci = g_bit[i-1].co;
        end

        fa_17bit_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .c  (ci),
            .s  (S[i]),
            .co (co)
        );
    end

    assign cout = g_bit[width-1].co;
`endif

    assign ovf = (A[msb] == B[msb]) && (S[msb] != A[msb]);

    always_ff @(posedge clk) begin
        if (rst) begin
            S_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            S_q    <= S;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_fa_17bit.sv
// Self-checking bench for fa_17bit: directed corner cases, reset/enable behaviour and random vectors vs an arithmetic model.
module tb_fa_17bit;

    logic        clk;
    logic        rst;
    logic [16:0] A;
    logic [16:0] B;
    logic        cin;
    logic        en;
    logic [16:0] S;
    logic        cout;
    logic        ovf;
    logic [16:0] S_q;
    logic        cout_q;
    logic        ovf_q;

    int tests;
    int fails;

    logic [16:0] exp_s;
    logic        exp_c;
    logic        exp_o;

    fa_17bit #(.width(17)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .cin    (cin),
        .en     (en),
        .S      (S),
        .cout   (cout),
        .ovf    (ovf),
        .S_q    (S_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; overflow is the true signed sum leaving the 17-bit two's complement range.
    task automatic model(input logic [16:0] a, input logic [16:0] b, input logic c,
                         output logic [16:0] s, output logic co, output logic o);
        longint ua, ub, sa, sb, tot, st;
        ua  = longint'(a);
        ub  = longint'(b);
        tot = ua + ub + longint'(c);
        s   = tot[16:0];
        co  = tot[17];
        sa  = (ua >= 65536) ? ua - 131072 : ua;
        sb  = (ub >= 65536) ? ub - 131072 : ub;
        st  = sa + sb + longint'(c);
        o   = (st > 65535) || (st < -65536);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_comb(input string tag);
        model(A, B, cin, exp_s, exp_c, exp_o);
        check({tag, "_S"},    64'(S),    64'(exp_s));
        check({tag, "_cout"}, 64'(cout), 64'(exp_c));
        check({tag, "_ovf"},  64'(ovf),  64'(exp_o));
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; A = '0; B = '0; cin = 1'b0;

        edge_sample();
        check("rst_S_q",    64'(S_q),    64'h0);
        check("rst_cout_q", 64'(cout_q), 64'h0);
        check("rst_ovf_q",  64'(ovf_q),  64'h0);

        // Combinational path keeps tracking inputs while reset is held.
        A = 17'h00003; B = 17'h00004; cin = 1'b0;
        #10;
        check("comb_in_rst_S", 64'(S), 64'h7);
        check("rst_hold_S_q",  64'(S_q), 64'h0);

        rst = 1'b0; en = 1'b1; A = 17'h00003; B = 17'h00004; cin = 1'b1;
        edge_sample();
        check("cap_S_q",    64'(S_q),    64'h8);
        check("cap_cout_q", 64'(cout_q), 64'h0);

        en = 1'b0;
        A = 17'h1FFFF; B = 17'h00000; cin = 1'b1;
        #10;
        check("max_carry_S",    64'(S),    64'h0);
        check("max_carry_cout", 64'(cout), 64'h1);
        check("max_carry_ovf",  64'(ovf),  64'h0);
        edge_sample();
        check("hold_S_q",    64'(S_q),    64'h8);
        check("hold_cout_q", 64'(cout_q), 64'h0);

        A = 17'h0FFFF; B = 17'h00001; cin = 1'b0;
        #10;
        check("sovf_S",    64'(S),    64'h10000);
        check("sovf_cout", 64'(cout), 64'h0);
        check("sovf_ovf",  64'(ovf),  64'h1);
        en = 1'b1;
        edge_sample();
        check("sovf_S_q",   64'(S_q),   64'h10000);
        check("sovf_ovf_q", 64'(ovf_q), 64'h1);

        A = 17'h1FFFF; B = 17'h1FFFF; cin = 1'b1;
        #10;
        check("ones_S",    64'(S),    64'h1FFFF);
        check("ones_cout", 64'(cout), 64'h1);
        check("ones_ovf",  64'(ovf),  64'h0);
        edge_sample();
        check("ones_cout_q", 64'(cout_q), 64'h1);

        // Negative overflow: most negative plus itself.
        A = 17'h10000; B = 17'h10000; cin = 1'b0;
        #10;
        check_comb("negovf");

        // Reset wins over enable on the same edge.
        rst = 1'b1; en = 1'b1; A = 17'h0FFFF; B = 17'h00001; cin = 1'b0;
        edge_sample();
        check("rstprio_S_q",    64'(S_q),    64'h0);
        check("rstprio_cout_q", 64'(cout_q), 64'h0);
        check("rstprio_ovf_q",  64'(ovf_q),  64'h0);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            A   = 17'($urandom());
            B   = 17'($urandom());
            cin = 1'($urandom());
            en  = 1'b1;
            #10;
            check_comb("rand");
            edge_sample();
            model(A, B, cin, exp_s, exp_c, exp_o);
            check("rand_S_q",    64'(S_q),    64'(exp_s));
            check("rand_cout_q", 64'(cout_q), 64'(exp_c));
            check("rand_ovf_q",  64'(ovf_q),  64'(exp_o));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
